// File: rtl/imm_ext_stage.sv
// imm_ext_stage: registered immediate extender with skid-buffered valid/ready output; IMM_EXT_PERF_CNT_EN adds xfer_cnt
module imm_ext_stage #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int SHAMT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic [1:0]        mode_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm_out
`ifdef IMM_EXT_PERF_CNT_EN
  ,
  output logic [31:0]       xfer_cnt
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, nxt;
  logic [DATA_W-1:0] sx, zx, up, br, ext, skid;
  logic accept, consume;
  always_comb begin
    sx  = {{(DATA_W-IMM_W){imm_in[IMM_W-1]}}, imm_in};
    zx  = {{(DATA_W-IMM_W){1'b0}}, imm_in};
    up  = {imm_in, {(DATA_W-IMM_W){1'b0}}};
    br  = sx << SHAMT;
    ext = mode_in[1] ? (mode_in[0] ? br : up) : (mode_in[0] ? zx : sx);
  end
  always_ff @(posedge clk)
    state <= rst ? EMPTY : nxt;
  always_comb begin
    nxt = flush ? EMPTY :
          state == EMPTY ? (accept ? ONE : EMPTY) :
          state == ONE   ? (accept && !consume ? FULL : (!accept && consume ? EMPTY : ONE)) :
                           (consume ? ONE : FULL);
  end
  always_comb begin
    out_valid = state != EMPTY;
    in_ready  = state != FULL;
    accept    = in_valid && in_ready;
    consume   = out_valid && out_ready;
  end
  // FULL drains skid into main; otherwise a new entry lands in main unless main is still occupied
  always_ff @(posedge clk) begin
    if (rst) begin
      imm_out <= '0;
      skid    <= '0;
    end else if (!flush) begin
      if (state == FULL && consume) imm_out <= skid;
      else if (accept && (state == EMPTY || consume)) imm_out <= ext;
      else if (accept) skid <= ext;
    end
  end
`ifdef IMM_EXT_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) xfer_cnt <= '0;
    else if (consume && xfer_cnt != 32'hFFFF_FFFF) xfer_cnt <= xfer_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage: directed and random checks of imm_ext_stage against a queue-based reference
module tb_imm_ext_stage;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [15:0] imm_in = 0;
  logic [1:0] mode_in = 0;
  logic in_ready, out_valid;
  logic [31:0] imm_out;
  int passed = 0, total = 0;
  logic [31:0] q[$];
  logic [31:0] cnt_m = 0;
`ifdef IMM_EXT_PERF_CNT_EN
  logic [31:0] xfer_cnt;
`endif
  imm_ext_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .imm_in(imm_in), .mode_in(mode_in), .out_valid(out_valid), .out_ready(out_ready),
    .imm_out(imm_out)
`ifdef IMM_EXT_PERF_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_ext(input logic [15:0] v, input logic [1:0] m);
    longint s = longint'($signed(v));
    longint u = longint'(v);
    longint r = (m == 0) ? s : (m == 1) ? u : (m == 2) ? u * 65536 : s * 4;
    return r[31:0];
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic cyc();
    bit acc, con;
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
    if (q.size() > 0) chk("imm_out", imm_out, q[0]);
`ifdef IMM_EXT_PERF_CNT_EN
    chk("xfer_cnt", xfer_cnt, cnt_m);
`endif
    acc = in_valid && q.size() < 2;
    con = q.size() > 0 && out_ready;
    @(posedge clk);
    if (rst) begin
      q.delete();
      cnt_m = 0;
    end else begin
      if (con && cnt_m != 32'hFFFF_FFFF) cnt_m++;
      if (flush) q.delete();
      else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(ref_ext(imm_in, mode_in));
      end
    end
    @(negedge clk);
  endtask
  task automatic send(input logic [15:0] v, input logic [1:0] m, input logic [31:0] exp);
    out_ready = 1; in_valid = 1; imm_in = v; mode_in = m;
    cyc();
    in_valid = 0;
    chk("ext_value", imm_out, exp);
    chk("ext_valid", {31'b0, out_valid}, 32'd1);
    cyc();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_imm_out", imm_out, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_ready", {31'b0, in_ready}, 1);
    send(16'h8001, 2'b00, 32'hFFFF_8001);
    send(16'h8001, 2'b01, 32'h0000_8001);
    send(16'h1234, 2'b10, 32'h1234_0000);
    send(16'hFFFF, 2'b11, 32'hFFFF_FFFC);
    send(16'h0004, 2'b11, 32'h0000_0010);
    out_ready = 0; in_valid = 1; mode_in = 2'b01;
    for (int i = 1; i <= 3; i++) begin
      imm_in = 16'(i);
      cyc();
    end
    chk("bp_ready", {31'b0, in_ready}, 0);
    chk("bp_hold", imm_out, 32'h1);
    cyc();
    chk("bp_stable", imm_out, 32'h1);
    out_ready = 1;
    cyc();
    chk("bp_b", imm_out, 32'h2);
    cyc();
    in_valid = 0;
    chk("bp_c", imm_out, 32'h3);
    cyc();
    cyc();
    rst = 1; cyc(); rst = 0;
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      imm_in = 16'(i);
      cyc();
      chk("stream_ready", {31'b0, in_ready}, 1);
      chk("stream_out", imm_out, 32'(i));
    end
    in_valid = 0;
    cyc();
`ifdef IMM_EXT_PERF_CNT_EN
    chk("cnt_8", xfer_cnt, 32'd8);
`endif
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      imm_in = 16'h10 + 16'(i);
      cyc();
    end
    flush = 1; imm_in = 16'hDEAD; cyc(); flush = 0; in_valid = 0;
    chk("flush_valid", {31'b0, out_valid}, 0);
    chk("flush_ready", {31'b0, in_ready}, 1);
`ifdef IMM_EXT_PERF_CNT_EN
    chk("flush_cnt", xfer_cnt, 32'd8);
`endif
    out_ready = 1; cyc(); cyc();
    in_valid = 1; out_ready = 0; imm_in = 16'h7777; mode_in = 2'b10;
    cyc(); cyc();
    rst = 1; cyc(); rst = 0; in_valid = 0;
    chk("mid_rst_out", imm_out, 0);
    chk("mid_rst_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_ready", {31'b0, in_ready}, 1);
`ifdef IMM_EXT_PERF_CNT_EN
    chk("mid_rst_cnt", xfer_cnt, 0);
    force dut.xfer_cnt = 32'hFFFF_FFFE;
    #1 release dut.xfer_cnt;
    cnt_m = 32'hFFFF_FFFE;
    out_ready = 1; in_valid = 1;
    repeat (5) cyc();
    in_valid = 0; cyc();
    chk("cnt_sat", xfer_cnt, 32'hFFFF_FFFF);
    rst = 1; cyc(); rst = 0;
`endif
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      imm_in    = 16'($urandom);
      mode_in   = 2'($urandom);
      flush     = $urandom_range(0, 31) == 0;
      rst       = $urandom_range(0, 99) == 0;
      cyc();
    end
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    cyc(); cyc(); cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
